cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It is the successor of the fixed 16-bit combinational CLA: the width is configurable, and the carry chain is split into registered slices so wide adds close timing. It adds subtract mode and status flags. It sits between operand-fetch logic and any downstream consumer that may apply backpressure.

---
 rtl/cla_pipe_adder.sv | 220 ++++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Parametrised, pipelined carry-lookahead adder/subtractor
//                with a valid/ready stream interface. The word is cut into
//                STAGES slices of WIDTH/STAGES bits. Each slice is resolved
//                with 4-bit lookahead groups and a second-level group
//                generate/propagate, using the carry registered by the
//                previous slice. Produces sum, carry-out, signed overflow
//                and zero flags.
//  Options     : CLA_PIPE_SAT_EN - when defined, the final stage applies
//                signed saturation on overflow (sum forced to max/min
//                according to the sign of operand A).
//  Constraints : WIDTH multiple of 4, >= 4; STAGES in 1..4;
//                (WIDTH/4) divisible by STAGES.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Slice geometry: SL bits per pipeline slice, NG lookahead groups per slice.
    localparam int SL   = WIDTH / STAGES;
    localparam int NG   = SL / 4;
    localparam int LAST = STAGES - 1;

    // ------------------------------------------------------------------------
    // Slice carry computation.
    // Returns the carry vector c[0..SL] of one slice: c[0] is the slice
    // carry-in, c[i] the carry into bit i, c[SL] the slice carry-out.
    // First level: 4-bit group generate/propagate. Second level: group
    // carries expanded in lookahead form from the group G/P terms.
    // ------------------------------------------------------------------------
    function automatic logic [SL:0] slice_carries(
        input logic [SL-1:0] x,
        input logic [SL-1:0] y,
        input logic          ci
    );
        logic [SL-1:0] g;
        logic [SL-1:0] p;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;
        logic [SL:0]   c;
        logic          t;

        g = x & y;
        p = x ^ y;

        // Group generate / propagate for each 4-bit group.
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end

        // Group carries: carry into group j from all lower groups and ci.
        for (int j = 0; j <= NG; j++) begin
            t = ci;
            for (int i = 0; i < j; i++) begin
                t = t & gp[i];
            end
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) begin
                    t = t & gp[m];
                end
                gc[j] = gc[j] | t;
            end
        end

        // Bit carries inside each group from the group carry-in.
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[SL] = gc[NG];
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state.
    // Level k holds the operands feeding slice k: full operands (upper bits
    // not yet consumed ride along), the carry into slice k, and the sum bits
    // already finished by lower slices. Level 0 is the input capture.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a [0:STAGES-1];
    logic [WIDTH-1:0] r_b [0:STAGES-1];
    logic [WIDTH-1:0] r_s [0:STAGES-1];
    logic             r_c [0:STAGES-1];
    logic             r_v [0:STAGES-1];

    // Output register: result plus flags, registered together.
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Combinational slice results.
    logic [SL:0]      w_carry  [0:STAGES-1];
    logic [WIDTH-1:0] w_next_s [0:STAGES-1];
    logic [WIDTH-1:0] w_fin_sum;
    logic             w_fin_cout;
    logic             w_fin_ovf;
    logic             w_fin_zero;
    logic             w_adv;

    // Whole pipeline moves together; it only holds when the output is
    // occupied and the consumer refuses it.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Resolve slice k at level k and merge it into the running sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_carry[k]  = slice_carries(r_a[k][k*SL +: SL], r_b[k][k*SL +: SL], r_c[k]);
            w_next_s[k] = r_s[k];
            w_next_s[k][k*SL +: SL] = r_a[k][k*SL +: SL] ^ r_b[k][k*SL +: SL]
                                    ^ w_carry[k][SL-1:0];
        end
    end

    // Final-stage flags from the full sum; carry into the MSB is bit SL-1
    // of the top slice's carry vector.
    always_comb begin
        w_fin_cout = w_carry[LAST][SL];
        w_fin_ovf  = w_carry[LAST][SL] ^ w_carry[LAST][SL-1];
        w_fin_sum  = w_next_s[LAST];
`ifdef CLA_PIPE_SAT_EN
        // Overflow direction follows the sign of A.
        if (w_fin_ovf) begin
            w_fin_sum = r_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        w_fin_zero = (w_fin_sum == '0);
    end

    // Stage registers: shift on advance, load data only behind a valid item
    // so bubbles and stalls leave the data registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            // Input capture: subtract is A + ~B + 1, cin ignored.
            r_v[0] <= in_valid;
            if (in_valid) begin
                r_a[0] <= a;
                r_b[0] <= b ^ {WIDTH{sub}};
                r_c[0] <= sub | cin;
            end

            // Intermediate slices hand their carry and partial sum onward.
            for (int k = 0; k < STAGES - 1; k++) begin
                r_v[k+1] <= r_v[k];
                if (r_v[k]) begin
                    r_a[k+1] <= r_a[k];
                    r_b[k+1] <= r_b[k];
                    r_s[k+1] <= w_next_s[k];
                    r_c[k+1] <= w_carry[k][SL];
                end
            end

            // Output register.
            r_out_valid <= r_v[LAST];
            if (r_v[LAST]) begin
                r_sum  <= w_fin_sum;
                r_cout <= w_fin_cout;
                r_ovf  <= w_fin_ovf;
                r_zero <= w_fin_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Self-checking bench for cla_pipe_adder. Two instances:
//                WIDTH=16/STAGES=2 and WIDTH=32/STAGES=4. Directed vector
//                table, backpressure stream, random sweep against an
//                arithmetic reference model, and reset mid-stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-bit instance signals
    logic        iv16 = 1'b0, or16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0;
    logic        ir16, ov16, co16, of16, z16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    // 32-bit instance signals
    logic        iv32 = 1'b0, or32 = 1'b1, cin32 = 1'b0, sub32 = 1'b0;
    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] a32 = '0, b32 = '0, s32;

    cla_pipe_adder #(.WIDTH(16), .STAGES(2)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .ovf(of16), .zero(z16)
    );

    cla_pipe_adder #(.WIDTH(32), .STAGES(4)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32),
        .sum(s32), .cout(co32), .ovf(of32), .zero(z32)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        longint m, ua, ub, ci, tot, sa, sb, st;
        res_t   r;
        m  = longint'(1) << w;
        ua = longint'({32'd0, a}) & (m - 1);
        ub = longint'({32'd0, b}) & (m - 1);
        ci = cin ? 1 : 0;
        if (sub) begin
            tot  = ua - ub;
            r.co = (ua >= ub);
        end else begin
            tot  = ua + ub + ci;
            r.co = (tot >= m);
        end
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        st = sub ? (sa - sb) : (sa + sb + ci);
        r.ov = (st > (m / 2 - 1)) || (st < -(m / 2));
        r.s  = 32'(tot & (m - 1));
`ifdef CLA_PIPE_SAT_EN
        if (r.ov) r.s = (sa < 0) ? 32'(m / 2) : 32'(m / 2 - 1);
`endif
        r.z = (r.s == 32'd0);
        return r;
    endfunction

    // Directed vector table for the 16-bit instance.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tv [8];

    // One isolated operation on the 16-bit instance: latency and results.
    task automatic apply16(input vec_t v, input int idx);
        int t0;
        bit seen;
        @(posedge clk); #1;
        a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; iv16 = 1'b1;
        @(negedge clk);
        t0 = cyc + 1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (ov16) seen = 1'b1;
        end
        check($sformatf("vec%0d_latency", idx), 64'(cyc - t0), 64'd2);
        check($sformatf("vec%0d_sum", idx),  s16,  v.s);
        check($sformatf("vec%0d_cout", idx), co16, v.co);
        check($sformatf("vec%0d_ovf", idx),  of16, v.ov);
        check($sformatf("vec%0d_zero", idx), z16,  v.z);
    endtask

    typedef struct {
        res_t r;
        int   t0;
    } inflight_t;

    initial begin
        logic [15:0] pa [8];
        logic [15:0] pb [8];
        logic        pc [8];
        logic        ps [8];
        res_t        q16 [$];
        inflight_t   q32 [$];
        res_t        e;
        inflight_t   f;
        int          sent, got, stalls;
        bit          held;
        logic [18:0] prev;

        // ------------------------------------------------------------ table
        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
`ifdef CLA_PIPE_SAT_EN
        tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
        tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tv[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
`endif
        tv[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tv[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        tv[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tv[7] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};

        // ------------------------------------------------------------ reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ov16, 1'b0);
        check("rst_in_ready",  ir16, 1'b1);
        check("rst_sum",       s16,  16'h0);
        check("rst_cout",      co16, 1'b0);
        check("rst_ovf",       of16, 1'b0);
        check("rst_zero",      z16,  1'b0);
        check("rst32_valid",   ov32, 1'b0);
        check("rst32_sum",     s32,  32'h0);

        // --------------------------------------------------------- directed
        for (int i = 0; i < 8; i++) apply16(tv[i], i);

        // ----------------------------------------------- backpressure stream
        for (int i = 0; i < 8; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
            pc[i] = 1'($urandom);
            ps[i] = 1'($urandom);
        end
        sent = 0; got = 0; stalls = 0; held = 1'b0; prev = '0;
        @(posedge clk); #1;
        or16 = 1'b1; iv16 = 1'b1;
        a16 = pa[0]; b16 = pb[0]; cin16 = pc[0]; sub16 = ps[0];
        for (int t = 0; t < 40 && got < 8; t++) begin
            @(negedge clk);
            if (iv16 && ir16) begin
                q16.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, sub16));
                sent++;
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    check("bp_spurious_output", 1'b1, 1'b0);
                end else begin
                    e = q16.pop_front();
                    check($sformatf("bp_result%0d", got), {s16, co16, of16, z16},
                          {e.s[15:0], e.co, e.ov, e.z});
                end
                got++;
            end
            if (ov16 && !or16) begin
                check("bp_stall_in_ready", ir16, 1'b0);
                if (held) check("bp_stall_stable", {s16, co16, of16, z16}, prev);
                prev = {s16, co16, of16, z16};
                held = 1'b1;
                stalls++;
            end else begin
                held = 1'b0;
            end
            @(posedge clk); #1;
            or16 = !((t + 1) >= 4 && (t + 1) <= 6);
            iv16 = (sent < 8);
            if (sent < 8) begin
                a16 = pa[sent]; b16 = pb[sent]; cin16 = pc[sent]; sub16 = ps[sent];
            end
        end
        iv16 = 1'b0; or16 = 1'b1;
        check("bp_results_count", 64'(got), 64'd8);
        check("bp_stall_cycles", 64'(stalls), 64'd3);

        // ------------------------------------------ 32-bit random sweep
        sent = 0; got = 0;
        @(posedge clk); #1;
        or32 = 1'b1;
        iv32 = ($urandom_range(0, 3) != 0);
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
        for (int t = 0; t < 4000 && got < 1000; t++) begin
            @(negedge clk);
            if (iv32 && ir32) begin
                f.r  = model(32, a32, b32, cin32, sub32);
                f.t0 = cyc + 1;
                q32.push_back(f);
                sent++;
            end
            if (ov32 && or32) begin
                if (q32.size() == 0) begin
                    check("rnd_spurious_output", 1'b1, 1'b0);
                end else begin
                    f = q32.pop_front();
                    check("rnd_result", {s32, co32, of32, z32}, {f.r.s, f.r.co, f.r.ov, f.r.z});
                    check("rnd_latency", 64'(cyc - f.t0), 64'd4);
                end
                got++;
            end
            @(posedge clk); #1;
            iv32 = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
        end
        iv32 = 1'b0;
        check("rnd_results_count", 64'(got), 64'd1000);

        // ------------------------------------------ reset mid-stream
        repeat (6) @(posedge clk);
        #1 iv32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
            @(negedge clk);
            check("midrst_accept", ir32, 1'b1);
            @(posedge clk); #1;
        end
        iv32 = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        @(negedge clk);
        check("midrst_sum_cleared", {s32, co32, of32, z32}, 35'd0);
        check("midrst_in_ready", ir32, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("midrst_no_stale", ov32, 1'b0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
